// File: rtl/stream_fifo.sv
// ---------------------------------------------------------------------------
// stream_fifo
//
// Single-clock stream FIFO with valid/ready handshakes on both sides.
//
// Storage is split in two stages:
//   - a RAM of DEPTH = 2**ADDR_LENGTH words, addressed by wrapping pointers;
//   - a registered show-ahead output stage that presents the head word.
// Total capacity is DEPTH + 1 words.
//
// count reports the words held in both stages. almost_full and almost_empty
// are thresholds on count, intended for upstream flow control.
//
// Optional feature macro: STREAM_FIFO_FLUSH_EN
//   When defined, a 'flush' input is added. A flush empties the FIFO the way
//   reset does, but leaves out_data untouched.
//
// Reset: 'reset' is synchronous and active-high. The clock is 'clk'.
// ---------------------------------------------------------------------------
module stream_fifo #(
  parameter int ADDR_LENGTH = 4,
  parameter int WORD_LENGTH = 8,
  parameter int AF_LEVEL    = (2 ** ADDR_LENGTH) - 2,
  parameter int AE_LEVEL    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  // Producer side
  input  logic [WORD_LENGTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  // Consumer side
  output logic [WORD_LENGTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef STREAM_FIFO_FLUSH_EN
  input  logic                   flush,
`endif
  // Fill level
  output logic [ADDR_LENGTH+1:0] count,
  output logic                   almost_full,
  output logic                   almost_empty
);

  localparam int DEPTH = 2 ** ADDR_LENGTH;

  // Thresholds sized to the counters they are compared against.
  localparam logic [ADDR_LENGTH:0]   DEPTH_C = DEPTH[ADDR_LENGTH:0];
  localparam logic [ADDR_LENGTH+1:0] AF_TH   = AF_LEVEL[ADDR_LENGTH+1:0];
  localparam logic [ADDR_LENGTH+1:0] AE_TH   = AE_LEVEL[ADDR_LENGTH+1:0];

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [WORD_LENGTH-1:0] mem [DEPTH];
  logic [ADDR_LENGTH-1:0] wr_ptr;
  logic [ADDR_LENGTH-1:0] rd_ptr;
  logic [ADDR_LENGTH:0]   ram_count;       // 0..DEPTH words held in RAM
  logic [ADDR_LENGTH:0]   ram_count_next;

  // ------------------------------------------------------------------------
  // Handshake decode
  // ------------------------------------------------------------------------
  logic push;       // word accepted from the producer this edge
  logic pop;        // word released to the consumer this edge
  logic refill;     // RAM head moves into the output register this edge
  logic ram_empty;
  logic ram_full;
  logic clear;      // flush request; empties both stages, keeps out_data

`ifdef STREAM_FIFO_FLUSH_EN
  assign clear = flush;
`else
  assign clear = 1'b0;
`endif

  // Full/empty come from the occupancy counter. The pointers alone cannot
  // tell a full RAM from an empty one because they wrap modulo DEPTH.
  assign ram_empty = (ram_count == '0);
  assign ram_full  = (ram_count == DEPTH_C);

  // in_ready depends only on registers, so it never depends on in_valid.
  assign in_ready  = !ram_full;

  assign push   = in_valid  && in_ready;
  assign pop    = out_valid && out_ready;

  // Show-ahead refill: the output register takes the RAM head whenever it is
  // empty or its word is leaving. A word pushed into an empty RAM is visible
  // to this logic one edge later, because there is no bypass path.
  assign refill = !ram_empty && (!out_valid || pop);

  // ------------------------------------------------------------------------
  // RAM occupancy arithmetic: +1 on push, -1 on refill, net 0 when both occur
  // ------------------------------------------------------------------------
  // Next RAM occupancy from this edge's push and refill decisions.
  always_comb begin
    // NOTE: give every always_comb output a value before any branch. A path
    // that leaves it unassigned infers a latch.
    ram_count_next = ram_count;
    unique case ({push, refill})
      2'b10:   ram_count_next = ram_count + 1'b1;
      2'b01:   ram_count_next = ram_count - 1'b1;
      default: ram_count_next = ram_count;
    endcase
  end

  // ------------------------------------------------------------------------
  // RAM write port
  // ------------------------------------------------------------------------
  // Write the accepted word at the tail. Writes are dropped during reset or
  // flush so that discarded words never land in storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. Its contents are never seen
    // before they are written, so clearing it would only add logic.
    if (push && !reset && !clear) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // ------------------------------------------------------------------------
  // Pointers and occupancy
  // ------------------------------------------------------------------------
  // Advance the wrapping pointers and update the occupancy. Reset and flush
  // both return them to zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the edge no matter how the code is ordered.
    if (reset || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_LENGTH'(1);
      end
      if (refill) begin
        rd_ptr <= rd_ptr + ADDR_LENGTH'(1);
      end
      ram_count <= ram_count_next;
    end
  end

  // ------------------------------------------------------------------------
  // Output stage
  // ------------------------------------------------------------------------
  // Output valid: set by a refill, cleared by a pop that finds the RAM
  // empty, and held otherwise.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      out_valid <= 1'b0;
    end else if (refill) begin
      out_valid <= 1'b1;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

  // Output data: loads only on a refill. It is therefore stable while a word
  // waits to be popped. Reset clears it; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
    end else if (refill && !clear) begin
      out_data <= mem[rd_ptr];
    end
  end

  // ------------------------------------------------------------------------
  // Fill level and flags (combinational from registers)
  // ------------------------------------------------------------------------
  assign count        = {1'b0, ram_count} + {{(ADDR_LENGTH+1){1'b0}}, out_valid};
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

endmodule

// File: tb/tb_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_stream_fifo
//
// Self-checking bench for stream_fifo, configured with ADDR_LENGTH = 2.
// That gives DEPTH = 4, a total capacity of 5, and AF_LEVEL = 2.
//
// The reference model holds the FIFO as a queue of RAM words plus an
// optional output word, and applies the transfer rules at each edge. It is
// compared against every DUT output after every edge. Directed steps add
// explicit constant expectations for the key scenarios.
//
// Build with +define+STREAM_FIFO_FLUSH_EN to include the flush scenario.
// ---------------------------------------------------------------------------
module tb_stream_fifo;

  localparam int AL    = 2;
  localparam int WL    = 8;
  localparam int DEPTH = 2 ** AL;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 1;
  localparam int N_STREAM = 3 * DEPTH * 5;   // 60 words, many pointer wraps

  logic          clk = 1'b0;
  logic          reset;
  logic [WL-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic [AL+1:0] count;
  logic          almost_full;
  logic          almost_empty;

  stream_fifo #(
    .ADDR_LENGTH (AL),
    .WORD_LENGTH (WL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
`ifdef STREAM_FIFO_FLUSH_EN
    .flush        (flush),
`endif
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [WL-1:0] m_ram[$];      // words waiting in RAM, oldest first
  logic          m_ov;          // output stage holds a word
  logic [WL-1:0] m_od;          // output stage word
  logic          m_push;        // last edge accepted a word
  logic          m_pop;         // last edge released a word
  logic [WL-1:0] dut_popped;    // DUT out_data just before that edge

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with the model.
  task automatic compare_all();
    int mc;
    mc = m_ram.size() + int'(m_ov);
    check("model_out_valid",    32'(out_valid),    32'(m_ov));
    check("model_out_data",     32'(out_data),     32'(m_od));
    check("model_count",        32'(count),        32'(mc));
    check("model_in_ready",     32'(in_ready),     32'(m_ram.size() < DEPTH));
    check("model_almost_full",  32'(almost_full),  32'(mc >= AF));
    check("model_almost_empty", 32'(almost_empty), 32'(mc <= AE));
  endtask

  // One clock edge. The inputs are already driven. The model advances by
  // the transfer rules, then the outputs are sampled 1 time unit after the
  // edge.
  task automatic step();
    int   rc;
    logic ov_before;
    rc         = m_ram.size();
    ov_before  = m_ov;
    m_push     = in_valid && (rc < DEPTH);
    m_pop      = m_ov && out_ready;
    dut_popped = out_data;
    @(posedge clk);
    #1;
    if (reset) begin
      m_ram.delete();
      m_ov = 1'b0;
      m_od = '0;
      m_push = 1'b0;
      m_pop  = 1'b0;
    end else if (flush) begin
      m_ram.delete();
      m_ov = 1'b0;
      m_push = 1'b0;
      m_pop  = 1'b0;
    end else begin
      if (rc > 0 && (!ov_before || m_pop)) begin
        m_od = m_ram.pop_front();
        m_ov = 1'b1;
      end else if (m_pop) begin
        m_ov = 1'b0;
      end
      if (m_push) m_ram.push_back(in_data);
    end
    compare_all();
  endtask

  initial begin
    int w;
    int n_got;
    int next_in;
    int exp_out;
    int cyc;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    m_ov      = 1'b0;
    m_od      = '0;

    // ---- Reset state ----
    step();
    step();
    check("rst_count",        32'(count),        0);
    check("rst_in_ready",     32'(in_ready),     1);
    check("rst_out_valid",    32'(out_valid),    0);
    check("rst_out_data",     32'(out_data),     0);
    check("rst_almost_full",  32'(almost_full),  0);
    check("rst_almost_empty", 32'(almost_empty), 1);
    reset = 1'b0;

    // ---- Single word latency: push 0xA5 at edge k, visible after k+1 ----
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();
    check("lat_edge_k_out_valid", 32'(out_valid), 0);
    in_valid = 1'b0;
    step();
    check("lat_out_valid",    32'(out_valid),    1);
    check("lat_out_data",     32'(out_data),     32'h A5);
    check("lat_count",        32'(count),        1);
    check("lat_almost_empty", 32'(almost_empty), 1);
    out_ready = 1'b1;
    step();
    check("lat_drained_count", 32'(count), 0);
    out_ready = 1'b0;

    // ---- Fill: offer 1..6 with out_ready low; only 1..5 fit ----
    w = 1;
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = WL'(w);
      step();
      if (m_push) w++;
    end
    check("fill_words_accepted", 32'(w - 1), 5);
    check("fill_count",          32'(count), 5);
    check("fill_in_ready",       32'(in_ready), 0);
    check("fill_almost_full",    32'(almost_full), 1);
    check("fill_head",           32'(out_data), 1);

    // ---- Drain: five pops return 1..5 in order ----
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("drain_word", 32'(dut_popped), 32'(i));
      if (i == 1) check("drain_in_ready_after_refill", 32'(in_ready), 1);
    end
    check("drain_count",     32'(count),     0);
    check("drain_out_valid", 32'(out_valid), 0);
    out_ready = 1'b0;

    // ---- Random-stall stream of an incrementing counter ----
    n_got   = 0;
    next_in = 0;
    exp_out = 0;
    m_push  = 1'b0;
    for (cyc = 0; cyc < 3000 && n_got < N_STREAM; cyc++) begin
      // A word that was offered but not taken stays on the bus.
      if (!(in_valid && !m_push)) begin
        in_valid = (next_in < N_STREAM) && ($urandom_range(0, 3) != 0);
        in_data  = WL'(next_in);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      check("stream_count_bound", 32'(count <= DEPTH + 1), 1);
      if (m_push) next_in++;
      if (m_pop) begin
        check("stream_order", 32'(dut_popped), 32'(WL'(exp_out)));
        exp_out++;
        n_got++;
      end
    end
    check("stream_all_received", 32'(n_got), 32'(N_STREAM));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step();
    out_ready = 1'b0;

    // ---- Reset with three words held ----
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = WL'(8'h10 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    check("mid_rst_before_count", 32'(count), 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_count",     32'(count),     0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_in_ready",  32'(in_ready),  1);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    step();
    in_valid = 1'b0;
    step();
    check("post_rst_out_valid", 32'(out_valid), 1);
    check("post_rst_out_data",  32'(out_data),  32'h3C);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

`ifdef STREAM_FIFO_FLUSH_EN
    // ---- Flush with four words held and a push offered ----
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = WL'(8'h50 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    check("flush_before_count", 32'(count), 4);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count",     32'(count),     0);
    check("flush_out_valid", 32'(out_valid), 0);
    check("flush_in_ready",  32'(in_ready),  1);
    step();
    check("flush_push_discarded", 32'(count), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
